// File: rtl/matvec_requant_stream.sv
// Requantizes one R-element accumulator vector (bias add, rounding shift, saturate, ReLU)
// and streams it out one element per beat; the next vector may be taken on the last beat.
module matvec_requant_stream #(
  parameter int R       = 8,
  parameter int W_Y     = 19,
  parameter int W_B     = 16,
  parameter int W_O     = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [R-1:0][W_Y-1:0]   s_y,
  input  logic [R-1:0][W_B-1:0]   bias,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic                    relu_en,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [W_O-1:0]          m_data,
  output logic [$clog2(R)-1:0]    m_idx,
  output logic                    m_last
);
  localparam int IW     = $clog2(R);
  localparam int W_S    = ((W_Y > W_B) ? W_Y : W_B) + 2;
  localparam int SH_MAX = W_S - 2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic signed [W_S:0] O_MAX = (W_S+1)'((2**(W_O-1)) - 1);
  localparam logic signed [W_S:0] O_MIN = (W_S+1)'(-(2**(W_O-1)));

  logic [0:0]                state_q, state_d;
  logic [R-1:0][W_Y-1:0]     y_q, y_d;
  logic [R-1:0][W_B-1:0]     b_q, b_d;
  logic [SHIFT_W-1:0]        shift_q, shift_d;
  logic                      relu_q, relu_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      accept, beat;

  assign m_valid = (state_q == BUSY);
  assign m_idx   = idx_q;
  assign m_last  = m_valid && (idx_q == IW'(R-1));
  assign beat    = m_valid && m_ready;
  // Combinational m_ready -> s_ready lets a new vector land on the last beat with no bubble.
  assign s_ready = (state_q == IDLE) || (beat && m_last);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    b_d     = b_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    idx_d   = idx_q;
    if (beat) begin
      idx_d = idx_q + 1'b1;
      if (m_last) state_d = IDLE;
    end
    if (accept) begin
      y_d     = s_y;
      b_d     = bias;
      shift_d = shift;
      relu_d  = relu_en;
      idx_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      y_q     <= '0;
      b_q     <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      b_q     <= b_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      idx_q   <= idx_d;
    end
  end

  // Datapath reads only the captured buffer and idx, so m_data never sees s_* directly.
  logic signed [W_S:0]  sum, half, rnd;
  logic [31:0]          sh;
  logic signed [W_O-1:0] sat;

  always_comb begin
    sum = (W_S+1)'($signed(y_q[idx_q])) + (W_S+1)'($signed(b_q[idx_q]));
    sh  = 32'(shift_q);
    if (sh > 32'(SH_MAX)) sh = 32'(SH_MAX);
    half = '0;
    if (sh != 0) half = (W_S+1)'(1) <<< (sh - 1);
    rnd = (sum + half) >>> sh;
    if (rnd > O_MAX)      sat = O_MAX[W_O-1:0];
    else if (rnd < O_MIN) sat = O_MIN[W_O-1:0];
    else                  sat = rnd[W_O-1:0];
    m_data = (relu_q && sat < 0) ? '0 : sat;
  end
endmodule

// File: tb/tb_matvec_requant_stream.sv
// Random and directed vectors against an arithmetic reference model; a forked monitor
// pops expected beats from a scoreboard queue and checks handshake stability.
module tb_matvec_requant_stream;
  localparam int R = 8, W_Y = 19, W_B = 16, W_O = 8, SHIFT_W = 5;
  localparam int IW = $clog2(R);

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  s_valid;
  logic                  s_ready;
  logic [R-1:0][W_Y-1:0] s_y;
  logic [R-1:0][W_B-1:0] bias;
  logic [SHIFT_W-1:0]    shift;
  logic                  relu_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [W_O-1:0]        m_data;
  logic [IW-1:0]         m_idx;
  logic                  m_last;

  matvec_requant_stream #(.R(R), .W_Y(W_Y), .W_B(W_B), .W_O(W_O), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_y(s_y), .bias(bias),
    .shift(shift), .relu_en(relu_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  int   beat_cyc[$];
  int   beats = 0;
  int   acc_cyc;
  int   rmode = 0;
  int   vy[R];
  int   vb[R];
  int   basic_y[R] = '{10, -10, 300, -300, 5, 6, 7, 8};
  int   ty[6] = '{5, -5, -6, -6, 262143, -262144};
  int   tbias[6] = '{2, 0, 0, 0, 32767, -32768};
  int   tsh[6] = '{1, 1, 2, 3, 31, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Exact integer requantization: floor((y+b + 2^(sh-1)) / 2^sh), clamp, optional ReLU.
  function automatic int ref_elem(input int y, input int b, input int shv, input bit relu);
    longint s, n, d, q;
    int     sh;
    s  = longint'(y) + longint'(b);
    sh = (shv > 19) ? 19 : shv;
    if (sh == 0) q = s;
    else begin
      n = s + (longint'(1) << (sh - 1));
      d = longint'(1) << sh;
      q = n / d;
      if ((n % d) != 0 && n < 0) q = q - 1;
    end
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    if (relu && q < 0) q = 0;
    return int'(q);
  endfunction

  task automatic rand_vec();
    for (int i = 0; i < R; i++) begin
      vy[i] = int'($urandom_range(0, (1 << W_Y) - 1)) - (1 << (W_Y - 1));
      vb[i] = int'($urandom_range(0, (1 << W_B) - 1)) - (1 << (W_B - 1));
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 after the accept with s_valid still high.
  task automatic send_vec(input int shv, input bit relu);
    int   n;
    bit   ok;
    exp_t e;
    for (int i = 0; i < R; i++) begin
      s_y[i]  = W_Y'(vy[i]);
      bias[i] = W_B'(vb[i]);
    end
    shift   = SHIFT_W'(shv);
    relu_en = relu;
    s_valid = 1'b1;
    n  = 0;
    ok = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (s_ready) ok = 1;
      else n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      acc_cyc = cyc;
      for (int i = 0; i < R; i++) begin
        e.data = ref_elem(vy[i], vb[i], shv, relu);
        e.idx  = i;
        e.last = (i == R - 1);
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    bit   stalled = 0;
    int   h_data, h_idx;
    bit   h_last;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stalled = 0;
        continue;
      end
      if (m_valid) chk("s_ready_busy", int'(s_ready), int'(m_ready && m_last));
      if (stalled) begin
        chk("hold_valid", int'(m_valid), 1);
        if (m_valid) begin
          chk("hold_data", int'($signed(m_data)), h_data);
          chk("hold_idx", int'(m_idx), h_idx);
          chk("hold_last", int'(m_last), int'(h_last));
        end
      end
      if (m_valid && m_ready) begin
        beat_cyc.push_back(cyc);
        beats++;
        stalled = 0;
        if (sbq.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("beat_data", int'($signed(m_data)), e.data);
          chk("beat_idx", int'(m_idx), e.idx);
          chk("beat_last", int'(m_last), int'(e.last));
        end
      end else if (m_valid) begin
        stalled = 1;
        h_data  = int'($signed(m_data));
        h_idx   = int'(m_idx);
        h_last  = m_last;
      end else stalled = 0;
    end
  endtask

  task automatic ready_driver();
    int k = 0;
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[k % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  endtask

  initial begin
    int base, n;
    rstn    = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    shift   = '0;
    relu_en = 1'b0;
    rand_vec();
    for (int i = 0; i < R; i++) begin
      s_y[i]  = W_Y'(vy[i]);
      bias[i] = W_B'(vb[i]);
    end
    fork
      monitor();
      ready_driver();
      begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset held with s_valid asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_idx", int'(m_idx), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_m_data", int'(m_data), 0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", int'(m_valid), 0);
    end
    @(posedge clk);
    #1;

    // Basic burst with latency and no gaps
    rmode = 0;
    for (int i = 0; i < R; i++) begin
      vy[i] = basic_y[i];
      vb[i] = 0;
    end
    beat_cyc.delete();
    send_vec(0, 0);
    s_valid = 1'b0;
    drain();
    chk("basic_beats", beat_cyc.size(), R);
    if (beat_cyc.size() == R) begin
      chk("basic_first_lat", beat_cyc[0], acc_cyc + 1);
      chk("basic_last_lat", beat_cyc[R-1], acc_cyc + R);
    end

    // ReLU on the same data
    send_vec(0, 1);
    s_valid = 1'b0;
    drain();

    // Rounding and saturation corner cases in element 0
    for (int t = 0; t < 6; t++) begin
      rand_vec();
      vy[0] = ty[t];
      vb[0] = tbias[t];
      send_vec(tsh[t], 0);
      s_valid = 1'b0;
      drain();
    end

    // Backpressure pattern with an ignored mid-burst s_valid pulse
    rmode = 1;
    rand_vec();
    send_vec(3, 0);
    for (int i = 0; i < R; i++) s_y[i] = W_Y'($urandom);
    @(negedge clk);
    chk("busy_s_ready", int'(s_ready), 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    drain();

    // Back-to-back vectors with s_valid held
    rmode = 0;
    beat_cyc.delete();
    rand_vec();
    send_vec(2, 0);
    rand_vec();
    send_vec(5, 1);
    base = acc_cyc;
    s_valid = 1'b0;
    drain();
    chk("b2b_beats", beat_cyc.size(), 2 * R);
    if (beat_cyc.size() == 2 * R) begin
      chk("b2b_no_bubble", beat_cyc[2*R-1] - beat_cyc[0], 2 * R - 1);
      chk("b2b_accept_on_last", base, beat_cyc[R-1]);
    end

    // Reset in the middle of a burst
    rand_vec();
    send_vec(1, 0);
    s_valid = 1'b0;
    base = beats;
    n = 0;
    while (beats < base + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (beats < base + 3) chk("mid_rst_wait", beats - base, 3);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_s_ready", int'(s_ready), 1);
    chk("mid_rst_m_idx", int'(m_idx), 0);
    sbq.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("after_rst_no_beat", int'(m_valid), 0);
      chk("after_rst_s_ready", int'(s_ready), 1);
    end
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int v = 0; v < 25; v++) begin
      rmode = int'($urandom_range(0, 2));
      rand_vec();
      send_vec(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    drain();
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
